// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit and its long-op scoreboard.
package hazard_pkg;

  // Forward-select encodings for the EX operand muxes.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Default register index width and the hard-wired zero register.
  localparam int AW_DEF = 5;
  typedef logic [AW_DEF-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/hazard_lat_timer.sv
// Countdown timer for the single long-latency unit; remembers which
// destination register the outstanding op will write.
module hazard_lat_timer #(
  parameter int AW = 5,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [LW-1:0] lat_i,
  input  logic [AW-1:0] dst_i,
  output logic          done_o,
  output logic          busy_o,
  output logic [AW-1:0] dst_o
);

  logic [LW-1:0] count_q, count_d;
  logic [AW-1:0] dst_q, dst_d;

  // Load on start (a latency of 0 behaves as 1), otherwise count down to 0.
  always_comb begin
    count_d = count_q;
    dst_d   = dst_q;
    if (start_i) begin
      count_d = (lat_i == '0) ? LW'(1) : lat_i;
      dst_d   = dst_i;
    end else if (count_q != '0) begin
      count_d = count_q - LW'(1);
    end
  end

  // Counter and tracked-destination registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dst_q   <= '0;
    end else begin
      count_q <= count_d;
      dst_q   <= dst_d;
    end
  end

  assign done_o = (count_q == LW'(1));
  assign busy_o = (count_q != '0);
  assign dst_o  = dst_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use and branch stalls, M/W forwarding, and a
// register scoreboard for one variable-latency (mul/div) unit.
// Optional feature macro: HZD_PERF_CNT_EN adds stall_cycles and
// sb_stall_cycles saturating counters.
//
// The decode instruction is checked against the pre-edge scoreboard, so a
// register released on an edge only becomes usable on the following cycle.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 16,
  parameter int LW      = $clog2(MAX_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_d,
  input  logic [AW-1:0]   rs_d,
  input  logic [AW-1:0]   rt_d,
  input  logic            use_rs_d,
  input  logic            use_rt_d,
  input  logic [AW-1:0]   dst_d,
  input  logic            regwrite_d,
  input  logic            branch_d,
  input  logic            long_d,
  input  logic [LW-1:0]   lat_d,
  input  logic [AW-1:0]   rs_e,
  input  logic [AW-1:0]   rt_e,
  input  logic [AW-1:0]   dst_e,
  input  logic            regwrite_e,
  input  logic            memtoreg_e,
  input  logic [AW-1:0]   dst_m,
  input  logic            regwrite_m,
  input  logic            memtoreg_m,
  input  logic [AW-1:0]   dst_w,
  input  logic            regwrite_w,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_e,
  output logic            fwd_a_d,
  output logic            fwd_b_d,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic [NREG-1:0] busy_vec,
`ifdef HZD_PERF_CNT_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     sb_stall_cycles,
`endif
  output logic            lu_busy
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [NREG-1:0] busy_q, busy_d;
  logic            tmr_done, tmr_busy;
  logic [AW-1:0]   tmr_dst;
  logic            lwstall, brstall, sbstall, stall_any, issue;
  logic            m_live, w_live, e_live, lm_live;
  logic [1:0]      fwd_a_e_c, fwd_b_e_c;

  // Scoreboard lookup; indices beyond NREG and register 0 read as idle.
  function automatic logic sb_bit(input logic [NREG-1:0] v, input logic [AW-1:0] idx);
    sb_bit = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (idx == AW'(i)) sb_bit = v[i];
    end
  endfunction

  assign m_live  = regwrite_m && (dst_m != ZERO_IDX);
  assign w_live  = regwrite_w && (dst_w != ZERO_IDX);
  assign e_live  = regwrite_e && (dst_e != ZERO_IDX);
  assign lm_live = memtoreg_m && (dst_m != ZERO_IDX);

  // EX operand forwarding, MEM result takes priority over WB.
  always_comb begin
    fwd_a_e_c = FWD_RF;
    fwd_b_e_c = FWD_RF;
    if (m_live && dst_m == rs_e)      fwd_a_e_c = FWD_M;
    else if (w_live && dst_w == rs_e) fwd_a_e_c = FWD_W;
    if (m_live && dst_m == rt_e)      fwd_b_e_c = FWD_M;
    else if (w_live && dst_w == rt_e) fwd_b_e_c = FWD_W;
  end

  // Stall sources: load-use, branch compare in ID, and scoreboard.
  always_comb begin
    lwstall = memtoreg_e && (dst_e != ZERO_IDX) &&
              ((use_rs_d && rs_d == dst_e) || (use_rt_d && rt_d == dst_e));
    brstall = branch_d &&
              ((e_live  && ((use_rs_d && rs_d == dst_e) || (use_rt_d && rt_d == dst_e))) ||
               (lm_live && ((use_rs_d && rs_d == dst_m) || (use_rt_d && rt_d == dst_m))));
    sbstall = valid_d &&
              ((use_rs_d && sb_bit(busy_q, rs_d)) ||
               (use_rt_d && sb_bit(busy_q, rt_d)) ||
               (regwrite_d && sb_bit(busy_q, dst_d)) ||
               (long_d && tmr_busy));
    stall_any = lwstall || brstall || sbstall;
    issue     = valid_d && long_d && !stall_any;
  end

  hazard_lat_timer #(.AW(AW), .LW(LW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (issue),
    .lat_i   (lat_d),
    .dst_i   (dst_d),
    .done_o  (tmr_done),
    .busy_o  (tmr_busy),
    .dst_o   (tmr_dst)
  );

  // Next scoreboard: release the tracked register on completion, mark the
  // issuing destination; register 0 never becomes busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (tmr_done && tmr_dst == AW'(i)) busy_d[i] = 1'b0;
      if (issue && dst_d == AW'(i))      busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard bit array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef HZD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, sb_cnt_q;

  // Saturating counters of total stall cycles and scoreboard stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      sb_cnt_q    <= '0;
    end else begin
      if (stall_any && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (sbstall && sb_cnt_q != 32'hFFFF_FFFF)      sb_cnt_q    <= sb_cnt_q + 32'd1;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign sb_stall_cycles = sb_cnt_q;
`endif

  // Hazard outputs are forced quiet while reset is held.
  assign stall_f  = rst_n && stall_any;
  assign stall_d  = rst_n && stall_any;
  assign flush_e  = rst_n && stall_any;
  assign fwd_a_d  = rst_n && m_live && (dst_m == rs_d);
  assign fwd_b_d  = rst_n && m_live && (dst_m == rt_d);
  assign fwd_a_e  = rst_n ? fwd_a_e_c : FWD_RF;
  assign fwd_b_e  = rst_n ? fwd_b_e_c : FWD_RF;
  assign busy_vec = busy_q;
  assign lu_busy  = tmr_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, branch,
// long-op scoreboard, structural/WAW stalls, async reset, perf counters.
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int LW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_d, use_rs_d, use_rt_d, regwrite_d, branch_d, long_d;
  logic [AW-1:0]   rs_d, rt_d, dst_d, rs_e, rt_e, dst_e, dst_m, dst_w;
  logic [LW-1:0]   lat_d;
  logic            regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
  logic            stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, lu_busy;
  logic [1:0]      fwd_a_e, fwd_b_e;
  logic [NREG-1:0] busy_vec;
`ifdef HZD_PERF_CNT_EN
  logic [31:0]     stall_cycles, sb_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  // Clock generation.
  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAX_LAT(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .dst_d(dst_d),
    .regwrite_d(regwrite_d), .branch_d(branch_d), .long_d(long_d), .lat_d(lat_d),
    .rs_e(rs_e), .rt_e(rt_e), .dst_e(dst_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .dst_m(dst_m), .regwrite_m(regwrite_m),
    .memtoreg_m(memtoreg_m), .dst_w(dst_w), .regwrite_w(regwrite_w),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .busy_vec(busy_vec),
`ifdef HZD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .sb_stall_cycles(sb_stall_cycles),
`endif
    .lu_busy(lu_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All three stall outputs must agree with one expected value.
  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_stall_f"}, 64'(stall_f), 64'(exp));
    chk({tag, "_stall_d"}, 64'(stall_d), 64'(exp));
    chk({tag, "_flush_e"}, 64'(flush_e), 64'(exp));
  endtask

  task automatic clr_inputs();
    valid_d = 0; use_rs_d = 0; use_rt_d = 0; regwrite_d = 0; branch_d = 0; long_d = 0;
    rs_d = 0; rt_d = 0; dst_d = 0; lat_d = 0;
    rs_e = 0; rt_e = 0; dst_e = 0; regwrite_e = 0; memtoreg_e = 0;
    dst_m = 0; regwrite_m = 0; memtoreg_m = 0; dst_w = 0; regwrite_w = 0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    clr_inputs();
    rst_n = 1'b0;
    regwrite_m = 1; dst_m = 3; rs_e = 3; rs_d = 3;
    memtoreg_e = 1; dst_e = 3; use_rs_d = 1;
    #2;
    chk("rst_fwd_a_e", 64'(fwd_a_e), 64'(2'b00));
    chk("rst_fwd_a_d", 64'(fwd_a_d), 64'(0));
    chk_stall("rst", 1'b0);
    chk("rst_busy_vec", 64'(busy_vec), 64'(0));
    chk("rst_lu_busy", 64'(lu_busy), 64'(0));
`ifdef HZD_PERF_CNT_EN
    chk("rst_stall_cycles", 64'(stall_cycles), 64'(0));
`endif
    clr_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- forwarding ----------------
    regwrite_m = 1; dst_m = 3; regwrite_w = 1; dst_w = 3; rs_e = 3; rt_e = 3;
    #1;
    chk("fwd_a_e_m", 64'(fwd_a_e), 64'(2'b10));
    chk("fwd_b_e_m", 64'(fwd_b_e), 64'(2'b10));
    regwrite_m = 0;
    #1;
    chk("fwd_a_e_w", 64'(fwd_a_e), 64'(2'b01));
    rt_e = 4;
    #1;
    chk("fwd_b_e_none", 64'(fwd_b_e), 64'(2'b00));
    regwrite_m = 1; dst_m = 0; dst_w = 0; rs_e = 0;
    #1;
    chk("fwd_a_e_r0", 64'(fwd_a_e), 64'(2'b00));
    dst_m = 3; rs_d = 3; rt_d = 4;
    #1;
    chk("fwd_a_d", 64'(fwd_a_d), 64'(1));
    chk("fwd_b_d", 64'(fwd_b_d), 64'(0));
    clr_inputs();
    tick();

    // ---------------- load-use ----------------
    valid_d = 1; memtoreg_e = 1; regwrite_e = 1; dst_e = 8; rs_d = 8; use_rs_d = 1;
    #1;
    chk_stall("lw_stall", 1'b1);
    tick();
    memtoreg_e = 0; regwrite_e = 0; dst_e = 0;
    memtoreg_m = 1; regwrite_m = 1; dst_m = 8;
    #1;
    chk_stall("lw_released", 1'b0);
    chk("lw_fwd_a_d", 64'(fwd_a_d), 64'(1));
    // branch waiting on a load in M, then on an ALU result in EX
    branch_d = 1;
    #1;
    chk_stall("br_load_m", 1'b1);
    memtoreg_m = 0; regwrite_e = 1; dst_e = 8;
    #1;
    chk_stall("br_alu_e", 1'b1);
    dst_e = 0; rs_d = 0;
    #1;
    chk_stall("br_r0", 1'b0);
    clr_inputs();
    tick();

    // ---------------- long op, dependent RAW ----------------
    valid_d = 1; long_d = 1; regwrite_d = 1; dst_d = 5; lat_d = 4;
    #1;
    chk_stall("long_issue", 1'b0);
    tick();
    long_d = 0; regwrite_d = 0; dst_d = 0; lat_d = 0; rs_d = 5; use_rs_d = 1;
    for (int i = 0; i < 4; i++) begin
      chk_stall($sformatf("raw_c%0d", i), 1'b1);
      chk($sformatf("raw_busy_c%0d", i), 64'(busy_vec), 64'(32'h0000_0020));
      chk($sformatf("raw_lu_c%0d", i), 64'(lu_busy), 64'(1));
      tick();
    end
    chk_stall("raw_issue", 1'b0);
    chk("raw_busy_clr", 64'(busy_vec), 64'(0));
    chk("raw_lu_clr", 64'(lu_busy), 64'(0));
    clr_inputs();
    tick();

    // ---------------- structural and WAW ----------------
    valid_d = 1; long_d = 1; regwrite_d = 1; dst_d = 6; lat_d = 2;
    tick();
    dst_d = 7; lat_d = 1;
    #1;
    chk_stall("struct_c0", 1'b1);
    tick();
    chk_stall("struct_c1", 1'b1);
    chk("struct_busy6", 64'(busy_vec), 64'(32'h0000_0040));
    tick();
    chk_stall("struct_free", 1'b0);
    chk("struct_busy_clr", 64'(busy_vec), 64'(0));
    tick();
    chk("struct_busy7", 64'(busy_vec), 64'(32'h0000_0080));
    chk("struct_lu", 64'(lu_busy), 64'(1));
    long_d = 0; lat_d = 0;
    #1;
    chk_stall("waw", 1'b1);
    tick();
    chk_stall("waw_free", 1'b0);
    chk("waw_busy_clr", 64'(busy_vec), 64'(0));
    clr_inputs();

    // ---------------- long op to r0 ----------------
    valid_d = 1; long_d = 1; regwrite_d = 1; dst_d = 0; lat_d = 3;
    tick();
    clr_inputs();
    chk("r0_busy_vec", 64'(busy_vec), 64'(0));
    chk("r0_lu", 64'(lu_busy), 64'(1));
    tick(); tick(); tick();
    chk("r0_lu_done", 64'(lu_busy), 64'(0));

    // ---------------- lat_d == 0 behaves as 1 ----------------
    valid_d = 1; long_d = 1; regwrite_d = 1; dst_d = 9; lat_d = 0;
    tick();
    clr_inputs();
    chk("lat0_busy", 64'(busy_vec), 64'(32'h0000_0200));
    tick();
    chk("lat0_clr", 64'(busy_vec), 64'(0));
    chk("lat0_lu", 64'(lu_busy), 64'(0));

    // ---------------- async reset mid-op ----------------
    valid_d = 1; long_d = 1; regwrite_d = 1; dst_d = 10; lat_d = 4;
    tick();
    long_d = 0; regwrite_d = 0; dst_d = 0; lat_d = 0; rs_d = 10; use_rs_d = 1;
    tick(); tick();
    chk_stall("pre_rst", 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_vec), 64'(0));
    chk("arst_lu", 64'(lu_busy), 64'(0));
    chk_stall("arst", 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_busy_%0d", i), 64'(busy_vec), 64'(0));
      chk($sformatf("post_rst_lu_%0d", i), 64'(lu_busy), 64'(0));
      chk_stall($sformatf("post_rst_%0d", i), 1'b0);
    end
    clr_inputs();

`ifdef HZD_PERF_CNT_EN
    // ---------------- perf counters: 3 sb + 1 lw ----------------
    chk("perf_zero", 64'(stall_cycles), 64'(0));
    valid_d = 1; long_d = 1; regwrite_d = 1; dst_d = 11; lat_d = 4;
    tick();
    long_d = 0; regwrite_d = 0; dst_d = 0; lat_d = 0; rs_d = 11; use_rs_d = 1;
    tick(); tick(); tick();
    valid_d = 0; rs_d = 8; memtoreg_e = 1; dst_e = 8;
    tick();
    clr_inputs();
    #1;
    chk("perf_stall_cycles", 64'(stall_cycles), 64'(4));
    chk("perf_sb_cycles", 64'(sb_stall_cycles), 64'(3));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
